// File: rtl/os_array_if.sv
// Control/status bundle between a tile sequencer (master) and the output-stationary
// array controller (slave).
interface os_array_if #(
  parameter int unsigned K_WIDTH = 16,
  parameter int unsigned WIDTH_T = 2,
  parameter int unsigned ROWS    = 4
);
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic               start;
  logic [K_WIDTH-1:0] k_len;
  logic [WIDTH_T-1:0] thres_cfg;
  logic               stall;
  logic               out_ready;
  logic               busy;
  logic               done;
  logic               feed_en;
  logic               pipeline_en;
  logic               reg_clear;
  logic               cell_en;
  logic               cscan_en;
  logic               c_switch;
  logic [WIDTH_T-1:0] Thres;
  logic               out_valid;
  logic [RowW-1:0]    row_idx;

  modport master (
    output start, k_len, thres_cfg, stall, out_ready,
    input  busy, done, feed_en, pipeline_en, reg_clear, cell_en, cscan_en, c_switch,
    input  Thres, out_valid, row_idx
  );

  modport slave (
    input  start, k_len, thres_cfg, stall, out_ready,
    output busy, done, feed_en, pipeline_en, reg_clear, cell_en, cscan_en, c_switch,
    output Thres, out_valid, row_idx
  );
endinterface

// File: rtl/os_array_controller.sv
// Sequencer for an output-stationary PE array: clear, skewed feed, pipeline flush,
// row-by-row result scan, completion pulse.
module os_array_controller #(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLS    = 4,
  parameter int unsigned STAGE   = 5,
  parameter int unsigned K_WIDTH = 16,
  parameter int unsigned WIDTH_T = 2
) (
  input logic       clk,
  input logic       rst_n,
  os_array_if.slave bus
);
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  // Shared feed/flush counter; sized for the longest feed plus the flush length.
  localparam int unsigned CntW = K_WIDTH + $clog2(ROWS + COLS + STAGE + 3) + 1;

  typedef enum logic [2:0] {StIdle, StClear, StFeed, StFlush, StScan, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [K_WIDTH-1:0] k_len_q, k_len_d;
  logic [WIDTH_T-1:0] thres_q, thres_d;
  logic               scan_first_q, scan_first_d;
  logic [CntW-1:0]    feed_last;
  logic [CntW-1:0]    flush_last;

  // Feed covers k_len plus the row/column skew: k_len + ROWS + COLS - 2 cycles.
  assign feed_last  = CntW'(k_len_q) + CntW'(ROWS + COLS) - CntW'(3);
  assign flush_last = CntW'(STAGE + 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      row_q        <= '0;
      k_len_q      <= '0;
      thres_q      <= '0;
      scan_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      k_len_q      <= k_len_d;
      thres_q      <= thres_d;
      scan_first_q <= scan_first_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    row_d           = row_q;
    k_len_d         = k_len_q;
    thres_d         = thres_q;
    scan_first_d    = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.feed_en     = 1'b0;
    bus.pipeline_en = 1'b0;
    bus.reg_clear   = 1'b0;
    bus.cell_en     = 1'b0;
    bus.cscan_en    = 1'b0;
    bus.c_switch    = 1'b0;
    bus.out_valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          k_len_d = bus.k_len;
          thres_d = bus.thres_cfg;
          cnt_d   = '0;
          row_d   = '0;
          state_d = (bus.k_len != '0) ? StClear : StDone;
        end
      end
      StClear: begin
        bus.busy      = 1'b1;
        bus.reg_clear = 1'b1;
        cnt_d         = '0;
        state_d       = StFeed;
      end
      StFeed: begin
        bus.busy        = 1'b1;
        bus.cell_en     = 1'b1;
        bus.pipeline_en = !bus.stall;
        bus.feed_en     = !bus.stall;
        if (!bus.stall) begin
          if (cnt_q == feed_last) begin
            cnt_d   = '0;
            state_d = StFlush;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFlush: begin
        bus.busy        = 1'b1;
        bus.pipeline_en = 1'b1;
        bus.cell_en     = 1'b1;
        if (cnt_q == flush_last) begin
          cnt_d        = '0;
          scan_first_d = 1'b1;
          state_d      = StScan;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StScan: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.cscan_en  = bus.out_ready;
        bus.c_switch  = scan_first_q;
        if (bus.out_ready) begin
          if (row_q == RowW'(ROWS - 1)) begin
            row_d   = '0;
            state_d = StDone;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      StDone: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.row_idx = row_q;
  assign bus.Thres   = thres_q;
endmodule

// File: tb/tb_os_array_controller.sv
// Self-checking bench: per-cycle comparison of all controller outputs against a
// phase-duration model derived from k_len, stall and out_ready patterns.
module tb_os_array_controller;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int STAGE = 5;
  localparam int K_WIDTH = 16;
  localparam int WIDTH_T = 2;
  localparam int MAXC = 256;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic stall_a [MAXC];
  logic rdy_a   [MAXC];
  logic [12:0] obs;

  os_array_if #(.K_WIDTH(K_WIDTH), .WIDTH_T(WIDTH_T), .ROWS(ROWS)) bus ();

  os_array_controller #(
    .ROWS(ROWS), .COLS(COLS), .STAGE(STAGE), .K_WIDTH(K_WIDTH), .WIDTH_T(WIDTH_T)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.busy, bus.done, bus.feed_en, bus.pipeline_en, bus.reg_clear, bus.cell_en,
                bus.cscan_en, bus.c_switch, bus.out_valid, bus.row_idx, bus.Thres};

  function automatic logic [12:0] pk(bit busy, bit done, bit fe, bit pe, bit rc, bit ce,
                                     bit cs, bit sw, bit ov, int ri, int th);
    logic [1:0] r2;
    logic [1:0] t2;
    r2 = ri[1:0];
    t2 = th[1:0];
    return {busy, done, fe, pe, rc, ce, cs, sw, ov, r2, t2};
  endfunction

  task automatic fill_arrays(input int stall_pct, input int rdy_pct);
    for (int i = 0; i < MAXC; i++) begin
      stall_a[i] = (i < 100) && ($urandom_range(99) < stall_pct);
      rdy_a[i]   = (i >= 100) || ($urandom_range(99) < rdy_pct);
    end
  endtask

  // Runs one tile from a start pulse; done_cyc is the first cycle done was seen (-1 if none).
  task automatic run_tile(input string name, input int k, input int thr, input int rep_cyc,
                          input int rst_cyc, output int done_cyc);
    logic [12:0] exp_v [MAXC];
    int f, c, n, r, last;
    for (int i = 0; i < MAXC; i++) exp_v[i] = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, thr);
    f = k + ROWS + COLS - 2;
    if (k == 0) begin
      exp_v[1] = pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, thr);
      last = 1;
    end else begin
      exp_v[1] = pk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, thr);
      c = 2;
      n = 0;
      while (n < f) begin
        exp_v[c] = pk(1, 0, !stall_a[c], !stall_a[c], 0, 1, 0, 0, 0, 0, thr);
        if (!stall_a[c]) n++;
        c++;
      end
      for (int i = 0; i < STAGE + 3; i++) begin
        exp_v[c] = pk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, thr);
        c++;
      end
      r = 0;
      n = c;
      while (r < ROWS) begin
        exp_v[c] = pk(1, 0, 0, 0, 0, 0, rdy_a[c], c == n, 1, r, thr);
        if (rdy_a[c]) r++;
        c++;
      end
      exp_v[c] = pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, thr);
      last = c;
    end

    done_cyc = -1;
    bus.start     = 1'b1;
    bus.k_len     = K_WIDTH'(k);
    bus.thres_cfg = WIDTH_T'(thr);
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.k_len     = K_WIDTH'($urandom);
    bus.thres_cfg = WIDTH_T'($urandom);
    for (int cy = 1; cy <= last + 1; cy++) begin
      bus.stall     = stall_a[cy];
      bus.out_ready = rdy_a[cy];
      if (cy == rep_cyc) begin
        bus.start     = 1'b1;
        bus.k_len     = K_WIDTH'(7);
        bus.thres_cfg = WIDTH_T'(3);
      end
      if (cy == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 13'd0) begin
          errors++;
          $display("FAIL %s reset_immediate cycle %0d: got %b expected %b", name, cy, obs, 13'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 13'd0) begin
          errors++;
          $display("FAIL %s reset_held cycle %0d: got %b expected %b", name, cy, obs, 13'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
      checks++;
      if (obs !== exp_v[cy]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, cy, obs, exp_v[cy]);
      end
      if (bus.done === 1'b1 && done_cyc < 0) done_cyc = cy;
      @(posedge clk);
      #1;
      if (cy == rep_cyc) bus.start = 1'b0;
    end
  endtask

  task automatic check_done(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.thres_cfg = '0;
    bus.stall = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", obs, 13'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected %b", obs, 13'd0);
    end
  endtask

  task automatic test_basic();
    int d;
    fill_arrays(0, 100);
    run_tile("basic", 3, 2, -1, -1, d);
    check_done("basic", d, 23);
  endtask

  task automatic test_stall();
    int d;
    fill_arrays(0, 100);
    stall_a[4] = 1'b1;
    stall_a[5] = 1'b1;
    run_tile("stall", 3, 1, -1, -1, d);
    check_done("stall", d, 25);
  endtask

  task automatic test_backpressure();
    int d;
    fill_arrays(0, 100);
    for (int i = 20; i <= 22; i++) rdy_a[i] = 1'b0;
    run_tile("backpressure", 3, 3, -1, -1, d);
    check_done("backpressure", d, 26);
  endtask

  task automatic test_zero_k();
    int d;
    fill_arrays(0, 100);
    run_tile("zero_k", 0, 2, -1, -1, d);
    check_done("zero_k", d, 1);
  endtask

  task automatic test_reset_abort();
    int d;
    fill_arrays(0, 100);
    run_tile("abort", 3, 2, -1, 8, d);
    check_done("abort_no_done", d, -1);
    run_tile("after_abort", 3, 1, -1, -1, d);
    check_done("after_abort", d, 23);
  endtask

  task automatic test_ignore_start();
    int d;
    fill_arrays(0, 100);
    run_tile("ignore_start", 3, 1, 10, -1, d);
    check_done("ignore_start", d, 23);
  endtask

  task automatic test_random();
    int d;
    int k;
    for (int it = 0; it < 20; it++) begin
      k = (it % 5 == 4) ? 0 : int'($urandom_range(12, 1));
      fill_arrays(25, 70);
      run_tile("random", k, int'($urandom_range(3)), -1, -1, d);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_zero_k();
    test_reset_abort();
    test_ignore_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/os_array_controller.md
OS_ARRAY_CONTROLLER -- requirements
Module: os_array_controller

Interface
REQ-001 Parameter ROWS, default 4, rows of the output-stationary PE array.
REQ-002 Parameter COLS, default 4, columns of the PE array.
REQ-003 Parameter STAGE, default 5, MAC pipeline depth of one PE.
REQ-004 Parameter K_WIDTH, default 16, width of the accumulation-length field.
REQ-005 Parameter WIDTH_T, default 2, threshold field width.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 clk  in  1  clock; all state changes on its rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  request a tile computation; sampled only in IDLE.
REQ-010 k_len  in  K_WIDTH  accumulation steps; latched when start is accepted.
REQ-011 thres_cfg  in  WIDTH_T  threshold; latched when start is accepted.
REQ-012 stall  in  1  operand source not ready; honoured only in FEED.
REQ-013 out_ready  in  1  result sink accepts a scanned row.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 feed_en  out  1  advance the act/wei edge feeders.
REQ-017 pipeline_en, reg_clear, cell_en, cscan_en, c_switch  out  1 each  array-wide PE controls.
REQ-018 Thres  out  WIDTH_T  latched thres_cfg, broadcast to the PEs.
REQ-019 out_valid  out  1  a scanned row is presented.
REQ-020 row_idx  out  $clog2(ROWS)  index of the row being scanned.

Function
REQ-021 The FSM SHALL have six states: IDLE, CLEAR, FEED, FLUSH, SCAN and DONE.
REQ-022 IDLE behaviour:
- start=1 and k_len!=0: go to CLEAR.
- start=1 and k_len==0: go to DONE, with no reg_clear.
- start=0: stay in IDLE.
REQ-023 CLEAR SHALL last exactly one cycle with reg_clear=1 and pipeline_en=0, then go to FEED with the counter at 0.
REQ-024 FEED total length SHALL be F = k_len + ROWS + COLS - 2 non-stalled cycles, covering the skew.
REQ-025 FEED outputs, combinational from state and stall:
- cell_en=1.
- pipeline_en = feed_en = !stall.
- The counter SHALL increment only when stall=0.
REQ-026 FEED SHALL go to FLUSH after F non-stalled cycles have completed.
REQ-027 FLUSH SHALL last STAGE+3 cycles with pipeline_en=1, cell_en=1, feed_en=0, and stall ignored; it then goes to SCAN.
REQ-028 On the first SCAN cycle, c_switch SHALL be 1 for that cycle only.
REQ-029 SCAN outputs:
- out_valid=1.
- pipeline_en=0, cell_en=0.
- cscan_en = out_ready, combinational.
REQ-030 In SCAN, row_idx SHALL start at 0 and increment on each out_valid&out_ready handshake; it holds when out_ready=0.
REQ-031 After the handshake with row_idx=ROWS-1, SCAN SHALL go to DONE.
REQ-032 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-033 start while busy=1 SHALL be ignored.
REQ-034 k_len and thres_cfg changes while busy=1 SHALL have no effect.
REQ-035 Counters SHALL be wide enough for k_len max + ROWS + COLS - 2 without wrap.
REQ-036 Outputs not asserted by the current state SHALL be 0.

Reset
REQ-037 While rst_n=0, regardless of state:
- state = IDLE.
- Counters = 0, row_idx = 0, Thres = 0.
- All outputs = 0.
REQ-038 Reset asserted mid-operation SHALL abort immediately with no done pulse.
REQ-039 After reset is released, the first accepted start SHALL behave as if from power-up.

Verification
Common setup: ROWS=COLS=4, STAGE=5, start pulsed with edge 0 as reference.
REQ-040 k_len=3, stall=0, out_ready=1 -> reg_clear cycle 1; pipeline_en cycles 2-18; c_switch cycle 19; out_valid cycles 19-22 with row_idx 0..3; done cycle 23.
REQ-041 Same as REQ-040 with stall=1 on cycles 4-5 -> pipeline_en and feed_en low on cycles 4-5; done cycle 25.
REQ-042 Same as REQ-040 with out_ready=0 on cycles 20-22 -> row_idx held at 1, cscan_en low on those cycles; done cycle 26.
REQ-043 k_len=0 -> no reg_clear, no pipeline_en; done cycle 1; busy only cycle 1.
REQ-044 rst_n=0 at cycle 8 of a REQ-040 run -> all outputs 0 immediately, no done; a new start after release reproduces REQ-040 timing.
REQ-045 start re-pulsed at cycle 10 of a REQ-040 run, with k_len=7 and thres_cfg=3 -> ignored; timing unchanged and Thres keeps its latched value.
